// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: operation encodings and default sizes.
package shift_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SFT_W = 5;

    typedef enum logic [1:0] {
        OP_SRL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SLL  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

endpackage : shift_pkg

// File: rtl/barrel_shift_right.sv
// Logarithmic right barrel shifter, logical or arithmetic.
// Ports:
//   data_i  - operand
//   sft_i   - shift amount
//   arith_i - 1: fill vacated bits with data_i[WIDTH-1]; 0: fill with zeros
//   data_o  - shifted result (combinational)
module barrel_shift_right #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SFT_W = 5
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SFT_W-1:0] sft_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] data_o
);

    // One extra top bit carries the fill value so every stage is a signed shift.
    logic [WIDTH:0] stage;

    always_comb begin
        stage = {arith_i & data_i[WIDTH-1], data_i};
        for (int unsigned i = 0; i < SFT_W; i++) begin
            if (sft_i[i]) begin
                stage = (WIDTH+1)'($signed(stage) >>> (1 << i));
            end
        end
        data_o = stage[WIDTH-1:0];
    end

endmodule : barrel_shift_right

// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin arbiter in front of a shared barrel shifter with one
// registered result stage (valid/ready).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   reqN_valid/ready          - request handshake for port N (ready is combinational)
//   reqN_data/sft/op          - operand, shift amount, operation for port N
//   rsp_valid/ready           - result handshake
//   rsp_data, rsp_src         - registered result and originating port
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SFT_W = DEF_SFT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SFT_W-1:0] req0_sft,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SFT_W-1:0] req1_sft,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_src
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_src_q,   rsp_src_d;
    logic             prio_q,      prio_d;     // port favoured when both are valid

    logic             grant0, grant1, can_accept, accept;
    logic [WIDTH-1:0] sel_data, sh_in, sh_out, result;
    logic [SFT_W-1:0] sel_sft;
    shift_op_e        sel_op;

    // Arbitration, handshake and operand preparation.
    always_comb begin
        grant1     = req1_valid & (~req0_valid | prio_q);
        grant0     = req0_valid & ~grant1;
        can_accept = ~rsp_valid_q | rsp_ready;
        req0_ready = grant0 & can_accept & ~rst;
        req1_ready = grant1 & can_accept & ~rst;
        accept     = req0_ready | req1_ready;

        sel_data = grant1 ? req1_data : req0_data;
        sel_sft  = grant1 ? req1_sft  : req0_sft;
        sel_op   = shift_op_e'(grant1 ? req1_op : req0_op);

        // Left shift runs through the right shifter on the bit-reversed operand.
        sh_in = sel_data;
        if (sel_op == OP_SLL) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                sh_in[i] = sel_data[WIDTH-1-i];
            end
        end
    end

    barrel_shift_right #(
        .WIDTH (WIDTH),
        .SFT_W (SFT_W)
    ) u_shifter (
        .data_i  (sh_in),
        .sft_i   (sel_sft),
        .arith_i (sel_op == OP_SRA),
        .data_o  (sh_out)
    );

    // Result selection and next state of the output register.
    always_comb begin
        result = sh_out;
        if (sel_op == OP_SLL) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                result[i] = sh_out[WIDTH-1-i];
            end
        end else if (sel_op == OP_PASS) begin
            result = sel_data;
        end

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_src_d   = rsp_src_q;
        prio_d      = prio_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result;
            rsp_src_d   = grant1;
            prio_d      = ~grant1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_src_q   <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_src_q   <= rsp_src_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;

endmodule : shift_unit_arbiter

// File: tb/tb_shift_unit_arbiter.sv
// Randomized self-checking bench for shift_unit_arbiter against a
// transaction-level reference model.
module tb_shift_unit_arbiter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, r0, r1;
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;
    logic [1:0]  op0, op1;
    logic        rsp_valid, rsp_ready, rsp_src;
    logic [31:0] rsp_data;

    int errors = 0;
    int checks = 0;

    // Reference state: result register contents and the favoured port.
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_src;
    int          m_ptr;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.WIDTH(32), .SFT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (r0),
        .req0_data  (d0),
        .req0_sft   (s0),
        .req0_op    (op0),
        .req1_valid (v1),
        .req1_ready (r1),
        .req1_data  (d1),
        .req1_sft   (s1),
        .req1_op    (op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src)
    );

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] op);
        case (op)
            OP_SRL:  return d >> s;
            OP_SRA:  return 32'($signed(d) >>> s);
            OP_SLL:  return d << s;
            default: return d;
        endcase
    endfunction

    // -1: nobody granted
    function automatic int exp_grant();
        if (v0 && v1) return m_ptr;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    function automatic logic exp_ready(int p);
        return !rst && (exp_grant() == p) && (!m_valid || rsp_ready);
    endfunction

    // Advance one clock and the reference model; ends 1 time unit after the edge.
    task automatic tick();
        int          g;
        logic        acc;
        logic [31:0] r;
        g   = exp_grant();
        acc = (g >= 0) && (!m_valid || rsp_ready) && !rst;
        r   = (g == 1) ? ref_shift(d1, s1, op1) : ref_shift(d0, s0, op0);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_ptr = 0;
        end else if (acc) begin
            m_valid = 1'b1; m_data = r; m_src = g[0]; m_ptr = 1 - g;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
        d0 = $urandom; d1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
        op0 = 2'($urandom); op1 = 2'($urandom);
        #1;
        checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", r0, r1); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", rsp_data); end
        checks++; if (rsp_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b expected 0", rsp_src); end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_port0_ops();
        logic [31:0] vd [4] = '{32'h7AFAFAFA, 32'h8AFAFAFA, 32'h7AFAFAFA, 32'h7AFAFAFA};
        logic [4:0]  vs [4] = '{5'd4, 5'd4, 5'd4, 5'd9};
        logic [1:0]  vo [4] = '{OP_SRL, OP_SRA, OP_SLL, OP_PASS};
        logic [31:0] ve [4] = '{32'h07AFAFAF, 32'hF8AFAFAF, 32'hAFAFAFA0, 32'h7AFAFAFA};
        rsp_ready = 1'b1; v1 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            v0 = 1'b1;
            if (k < 4) begin d0 = vd[k]; s0 = vs[k]; op0 = vo[k]; end
            else begin d0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom); end
            #1;
            checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL p0_ready[%0d]: got %b%b expected 10", k, r0, r1); end
            tick();
            v0 = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b0) begin errors++; $display("FAIL p0_valid_src[%0d]: got %b/%b expected 1/0", k, rsp_valid, rsp_src); end
            if (k < 4) begin
                checks++; if (rsp_data !== ve[k]) begin errors++; $display("FAIL p0_vec[%0d]: got %h expected %h", k, rsp_data, ve[k]); end
            end else begin
                checks++; if (rsp_data !== m_data) begin errors++; $display("FAIL p0_rand[%0d]: got %h expected %h", k, rsp_data, m_data); end
            end
        end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL p0_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1; v0 = 1'b1; v1 = 1'b1;
        d1 = 32'h80000000; s1 = 5'd31; op1 = OP_SRL;
        for (int k = 0; k < 8; k++) begin
            d0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom);
            #1;
            checks++; if (r0 !== 1'(k % 2 == 0) || r1 !== 1'(k % 2 == 1)) begin errors++; $display("FAIL rr_ready[%0d]: got %b%b", k, r0, r1); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'(k % 2)) begin errors++; $display("FAIL rr_src[%0d]: got %b/%b expected 1/%0d", k, rsp_valid, rsp_src, k % 2); end
            if (k % 2 == 1) begin
                checks++; if (rsp_data !== 32'h00000001) begin errors++; $display("FAIL rr_p1_data[%0d]: got %h expected 00000001", k, rsp_data); end
            end else begin
                checks++; if (rsp_data !== m_data) begin errors++; $display("FAIL rr_p0_data[%0d]: got %h expected %h", k, rsp_data, m_data); end
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_data;
        logic        held_src;
        rsp_ready = 1'b1; v0 = 1'b1; v1 = 1'b0;
        d0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom);
        #1;
        tick();
        held_data = m_data; held_src = m_src;
        rsp_ready = 1'b0; v1 = 1'b1;
        d1 = $urandom; s1 = 5'($urandom); op1 = 2'($urandom);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b%b expected 00", k, r0, r1); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_src !== held_src) begin
                errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%b expected 1/%h/%b", k, rsp_valid, rsp_data, rsp_src, held_data, held_src);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (r0 !== exp_ready(0) || r1 !== exp_ready(1) || (r0 | r1) !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b%b", r0, r1); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== m_data || rsp_src !== m_src) begin
            errors++; $display("FAIL bp_release_rsp: got %b/%h/%b expected 1/%h/%b", rsp_valid, rsp_data, rsp_src, m_data, m_src);
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        rsp_ready = 1'b1; v1 = 1'b0;
        for (int s = 0; s < 32; s++) begin
            v0 = 1'b1; s0 = 5'(s);
            d0 = 32'h80000001; op0 = OP_SRA;
            #1;
            tick();
            checks++; if (rsp_data !== 32'($signed(32'h80000001) >>> s)) begin errors++; $display("FAIL sweep_sra[%0d]: got %h expected %h", s, rsp_data, m_data); end
            d0 = 32'h00000001; op0 = OP_SLL;
            #1;
            tick();
            checks++; if (rsp_data !== (32'h1 << s)) begin errors++; $display("FAIL sweep_sll[%0d]: got %h expected %h", s, rsp_data, 32'h1 << s); end
        end
        v0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1; v0 = 1'b0; v1 = 1'b1;
        d1 = $urandom; s1 = 5'($urandom); op1 = 2'($urandom);
        #1;
        tick();
        rsp_ready = 1'b0; v0 = 1'b1; rst = 1'b1;
        d0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom);
        #1;
        checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b%b expected 00", r0, r1); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rstmid_rsp: got %b/%h expected 0/00000000", rsp_valid, rsp_data); end
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL rstmid_grant: got %b%b expected 10", r0, r1); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b0 || rsp_data !== ref_shift(d0, s0, op0)) begin
            errors++; $display("FAIL rstmid_first: got %b/%b/%h expected 1/0/%h", rsp_valid, rsp_src, rsp_data, ref_shift(d0, s0, op0));
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            v0 = 1'($urandom_range(0, 3) != 0); v1 = 1'($urandom_range(0, 3) != 0);
            rsp_ready = 1'($urandom_range(0, 2) != 0);
            d0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom);
            d1 = $urandom; s1 = 5'($urandom); op1 = 2'($urandom);
            #1;
            checks++; if (r0 !== exp_ready(0) || r1 !== exp_ready(1)) begin errors++; $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", k, r0, r1, exp_ready(0), exp_ready(1)); end
            tick();
            checks++; if (rsp_valid !== m_valid || rsp_data !== m_data || rsp_src !== m_src) begin
                errors++; $display("FAIL rand_rsp[%0d]: got %b/%h/%b expected %b/%h/%b", k, rsp_valid, rsp_data, rsp_src, m_valid, m_data, m_src);
            end
        end
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_ptr = 0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        d0 = '0; d1 = '0; s0 = '0; s1 = '0; op0 = '0; op1 = '0;
        test_reset();
        test_port0_ops();
        test_round_robin();
        test_backpressure();
        test_sweep();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_unit_arbiter

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one `barrel_shift_right` datapath between two requesters: port 0 is the execute-stage ALU, port 1 is the load/store byte-alignment logic.
- Supports logical right, arithmetic right and logical left shifts. Left shift is built by bit-reversing the operand and the result around the right shifter.
- One registered output stage with a valid/ready handshake and round-robin arbitration. Sits between the execute stage and the writeback/alignment paths.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SFT_W, 5, shift-amount width; WIDTH must equal 2**SFT_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_data  in  WIDTH  port 0 operand.
- req0_sft  in  SFT_W  port 0 shift amount.
- req0_op  in  2  port 0 operation: 00 SRL, 01 SRA, 10 SLL, 11 PASS.
- req1_valid, req1_ready, req1_data, req1_sft, req1_op  as port 0, for port 1.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  shifted result.
- rsp_src  out  1  index of the port whose request produced rsp_data.

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_src=0, priority pointer = port 0. While rst=1, req0_ready and req1_ready are forced to 0.
- can_accept = !rsp_valid | rsp_ready (combinational).
- Grant:
  - If only one port is valid, it is granted.
  - If both are valid, the port indicated by the priority pointer is granted.
  - The pointer moves to the other port only on an accepted grant (ready & valid); otherwise it holds.
- reqN_ready = grantN & can_accept & !rst. This is combinational from valid, rsp_valid and rsp_ready. A port that is not valid never sees ready=1.
- Accepted request: on the next edge, rsp_data = computed result, rsp_src = granted port, rsp_valid = 1. Latency is exactly 1 cycle from acceptance to rsp_valid.
- Held result: if rsp_valid=1 and rsp_ready=0, rsp_data and rsp_src are stable and no request is accepted.
- Drained result: if rsp_valid=1, rsp_ready=1 and no request is accepted, rsp_valid goes to 0 next cycle. rsp_data keeps its last value.
- Simultaneous consume and accept: the result register is overwritten in the same cycle. Full throughput is 1 result per cycle.
- Operations, with d = operand and s = shift amount:
  - SRL: shifter(d, s, arith=0).
  - SRA: shifter(d, s, arith=1); sign bit d[WIDTH-1] fills the vacated bits.
  - SLL: reverse(shifter(reverse(d), s, arith=0)).
  - PASS: d unchanged, regardless of s.
- s=0 returns d for every op. s=WIDTH-1 on SRA of a negative operand yields all ones.
- Reset mid-operation: a pending result is discarded (rsp_valid=0 on the next edge). No request is accepted in the reset cycle. The pointer returns to port 0.
- No X on any output after reset, whatever the input values.

Decomposition:
- Shared package shift_pkg holds:
  - the SHIFT_OP encodings (OP_SRL=2'b00, OP_SRA=2'b01, OP_SLL=2'b10, OP_PASS=2'b11);
  - default WIDTH/SFT_W constants.
- One sub-module: the existing `barrel_shift_right` (#(WIDTH, SFT_W)), instantiated once and fed from the grant mux.
- Bit reversal and the round-robin pointer stay inline; no further sub-modules.

Test Plan:
1. Port 0 only, rsp_ready=1:
   - SRL 0x7AFAFAFA by 4 -> 0x07AFAFAF, rsp_src=0, 1 cycle after acceptance.
   - SRA 0x8AFAFAFA by 4 -> 0xF8AFAFAF.
   - SLL 0x7AFAFAFA by 4 -> 0xAFAFAFA0.
   - PASS with s=9 -> 0x7AFAFAFA.
2. Both ports valid every cycle, rsp_ready=1, port 1 SRL 0x80000000 by 31:
   - grants alternate 0,1,0,1 starting with port 0;
   - rsp_src sequence matches;
   - port 1 results = 0x00000001.
3. Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles:
   - req0_ready=req1_ready=0;
   - rsp_data and rsp_src unchanged;
   - releasing rsp_ready accepts the next request in the same cycle.
4. Full sweep: s=0..31 with SRA on 0x80000001 and SLL on 0x00000001:
   - SRA matches the signed-shift reference model;
   - SLL gives 1<<s.
5. rst asserted while rsp_valid=1 and both ports valid:
   - next cycle rsp_valid=0, rsp_data=0;
   - ready outputs stay 0 during reset;
   - first grant after reset goes to port 0.
